// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; issues one registered training/recovery
// record per resolved branch and flushes younger entries on a mispredict. Optional stats: BRQ_STATS_EN.
module branch_resolve_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 32,
   parameter int GHR_W = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     pred_valid,
   output logic                     pred_ready,
   input  logic [PC_W-1:0]          pred_pc,
   input  logic                     pred_taken,
   input  logic                     pred_local,
   input  logic                     pred_global,
   input  logic [GHR_W-1:0]         pred_ghr,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     upd_valid,
   output logic [PC_W-1:0]          upd_pc,
   output logic                     upd_taken,
   output logic                     upd_mispredict,
   output logic                     upd_choice_inc,
   output logic                     upd_choice_dec,
   output logic [GHR_W-1:0]         upd_ghr,
   output logic [$clog2(DEPTH):0]   count,
   output logic [31:0]              stat_branches,
   output logic [31:0]              stat_mispredicts
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic             taken;
      logic             loc;
      logic             glob;
      logic [GHR_W-1:0] ghr;
   } entry_t;

   typedef struct packed {
      logic             valid;
      logic [PC_W-1:0]  pc;
      logic             taken;
      logic             mispredict;
      logic             choice_inc;
      logic             choice_dec;
      logic [GHR_W-1:0] ghr;
   } upd_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W:0]   head_q, head_d;
   logic [PTR_W:0]   tail_q, tail_d;
   upd_t             upd_q, upd_d;

   logic   empty;
   logic   full;
   logic   alloc;
   logic   res_fire;
   logic   mispredict;
   entry_t head_e;

   // Handshake: a prediction transfers on a rising edge where pred_valid && pred_ready;
   // pred_ready depends only on registered pointers (and reset), never on pred_valid/res_valid.
   // res_valid has no ready: it is honoured only when the queue is non-empty at cycle start.
   assign empty      = (head_q == tail_q);
   assign full       = (head_q[PTR_W] != tail_q[PTR_W]) &&
                       (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
   assign count      = tail_q - head_q;
   assign pred_ready = !full && !reset;
   assign head_e     = mem_q[head_q[PTR_W-1:0]];
   assign alloc      = pred_valid && pred_ready;
   assign res_fire   = res_valid && !empty;
   assign mispredict = head_e.taken ^ res_taken;

   always_comb begin
      mem_d = mem_q;
      if (alloc) begin
         mem_d[tail_q[PTR_W-1:0]] = '{pc:    pred_pc,
                                      taken: pred_taken,
                                      loc:   pred_local,
                                      glob:  pred_global,
                                      ghr:   pred_ghr};
      end
   end

   // A mispredict collapses the queue onto the popped head; a same-cycle allocation is wrong-path.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (res_fire) begin
         head_d = head_q + PTR_ONE;
      end
      if (res_fire && mispredict) begin
         tail_d = head_q + PTR_ONE;
      end else if (alloc) begin
         tail_d = tail_q + PTR_ONE;
      end
   end

   always_comb begin
      upd_d = '0;
      if (res_fire) begin
         upd_d.valid      = 1'b1;
         upd_d.pc         = head_e.pc;
         upd_d.taken      = res_taken;
         upd_d.mispredict = mispredict;
         upd_d.choice_inc = (head_e.glob == res_taken) && (head_e.loc != res_taken);
         upd_d.choice_dec = (head_e.loc == res_taken) && (head_e.glob != res_taken);
         upd_d.ghr        = {head_e.ghr[GHR_W-2:0], res_taken};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         upd_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         upd_q  <= upd_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign upd_valid      = upd_q.valid;
   assign upd_pc         = upd_q.pc;
   assign upd_taken      = upd_q.taken;
   assign upd_mispredict = upd_q.mispredict;
   assign upd_choice_inc = upd_q.choice_inc;
   assign upd_choice_dec = upd_q.choice_dec;
   assign upd_ghr        = upd_q.ghr;

`ifdef BRQ_STATS_EN
   logic [31:0] stat_br_q, stat_br_d;
   logic [31:0] stat_mp_q, stat_mp_d;

   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (res_fire && (stat_br_q != 32'hFFFF_FFFF)) begin
         stat_br_d = stat_br_q + 32'd1;
      end
      if (res_fire && mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
         stat_mp_d = stat_mp_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;

   localparam int DEPTH = 8;
   localparam int PC_W  = 32;
   localparam int GHR_W = 12;
   localparam int UW    = PC_W + 4 + GHR_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              pred_valid;
   logic              pred_ready;
   logic [PC_W-1:0]   pred_pc;
   logic              pred_taken;
   logic              pred_local;
   logic              pred_global;
   logic [GHR_W-1:0]  pred_ghr;
   logic              res_valid;
   logic              res_taken;
   logic              upd_valid;
   logic [PC_W-1:0]   upd_pc;
   logic              upd_taken;
   logic              upd_mispredict;
   logic              upd_choice_inc;
   logic              upd_choice_dec;
   logic [GHR_W-1:0]  upd_ghr;
   logic [$clog2(DEPTH):0] count;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_mispredicts;

   branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .GHR_W(GHR_W)) dut (
      .clock            (clock),
      .reset            (reset),
      .pred_valid       (pred_valid),
      .pred_ready       (pred_ready),
      .pred_pc          (pred_pc),
      .pred_taken       (pred_taken),
      .pred_local       (pred_local),
      .pred_global      (pred_global),
      .pred_ghr         (pred_ghr),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_mispredict   (upd_mispredict),
      .upd_choice_inc   (upd_choice_inc),
      .upd_choice_dec   (upd_choice_dec),
      .upd_ghr          (upd_ghr),
      .count            (count),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // clock / reset
   always #5 clock = ~clock;

   // reference model state
   typedef struct {
      logic [PC_W-1:0]  pc;
      logic             taken;
      logic             loc;
      logic             glob;
      logic [GHR_W-1:0] ghr;
   } ent_t;

   ent_t             model_q[$];
   logic [UW-1:0]    exp_q[$];
   logic [31:0]      exp_br;
   logic [31:0]      exp_mp;
   int               n_checks;
   int               n_pass;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // One clock cycle: drive at negedge, predict from the model, check after the edge.
   task automatic step(input logic rst, input logic pv, input logic [PC_W-1:0] pc,
                       input logic pt, input logic pl, input logic pg,
                       input logic [GHR_W-1:0] ghr, input logic rv, input logic rt);
      logic          exp_fire;
      logic          can_alloc;
      logic          mis;
      logic [UW-1:0] rec;
      ent_t          h;
      ent_t          n;
      @(negedge clock);
      reset       = rst;
      pred_valid  = pv;
      pred_pc     = pc;
      pred_taken  = pt;
      pred_local  = pl;
      pred_global = pg;
      pred_ghr    = ghr;
      res_valid   = rv;
      res_taken   = rt;
      #1;
      check("pred_ready", {63'd0, pred_ready}, {63'd0, (!rst && model_q.size() < DEPTH)});
      check("count", 64'(count), 64'(model_q.size()));
      exp_fire = 1'b0;
      if (rst) begin
         model_q.delete();
         exp_q.delete();
         exp_br = '0;
         exp_mp = '0;
      end else begin
         can_alloc = pv && (model_q.size() < DEPTH);
         mis = 1'b0;
         if (rv && model_q.size() > 0) begin
            h   = model_q.pop_front();
            mis = (h.taken != rt);
            rec = {h.pc, rt, mis, (h.glob == rt) && (h.loc != rt),
                   (h.loc == rt) && (h.glob != rt), h.ghr[GHR_W-2:0], rt};
            exp_q.push_back(rec);
            exp_fire = 1'b1;
`ifdef BRQ_STATS_EN
            if (exp_br != 32'hFFFF_FFFF) exp_br++;
            if (mis && exp_mp != 32'hFFFF_FFFF) exp_mp++;
`endif
            if (mis) model_q.delete();
         end
         if (can_alloc && !mis) begin
            n.pc = pc; n.taken = pt; n.loc = pl; n.glob = pg; n.ghr = ghr;
            model_q.push_back(n);
         end
      end
      @(posedge clock);
      #1;
      if (exp_fire) begin
         check("upd_valid", {63'd0, upd_valid}, 64'd1);
         rec = exp_q.pop_front();
         check("upd_record",
               64'({upd_pc, upd_taken, upd_mispredict, upd_choice_inc, upd_choice_dec, upd_ghr}),
               64'(rec));
      end else begin
         check("upd_valid", {63'd0, upd_valid}, 64'd0);
      end
      if (rst) begin
         check("upd_after_reset",
               64'({upd_pc, upd_taken, upd_mispredict, upd_choice_inc, upd_choice_dec, upd_ghr}),
               64'd0);
      end
      check("stat_branches", 64'(stat_branches), 64'(exp_br));
      check("stat_mispredicts", 64'(stat_mispredicts), 64'(exp_mp));
   endtask

   // driver tasks
   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic alloc(input logic [PC_W-1:0] pc, input logic pt, input logic pl,
                        input logic pg, input logic [GHR_W-1:0] ghr);
      step(1'b0, 1'b1, pc, pt, pl, pg, ghr, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic rt);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, rt);
   endtask

   task automatic drain();
      while (model_q.size() > 0) resolve(model_q[0].taken);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int pv_pct;
      logic rt;
      n_checks = 0;
      n_pass   = 0;
      exp_br   = '0;
      exp_mp   = '0;
      reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
      pred_local = 1'b0; pred_global = 1'b0; pred_ghr = '0;
      res_valid = 1'b0; res_taken = 1'b0;
      repeat (2) @(posedge clock);
      do_reset();

      // fill past capacity
      for (int i = 0; i < DEPTH + 1; i++) alloc(32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 12'(i));
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      drain();

      // in-order resolve
      alloc(32'h100, 1'b1, 1'b1, 1'b1, 12'h001);
      alloc(32'h104, 1'b1, 1'b1, 1'b1, 12'h002);
      alloc(32'h108, 1'b1, 1'b1, 1'b1, 12'h003);
      resolve(1'b1);
      check("inorder_pc0", 64'(upd_pc), 64'h100);
      resolve(1'b1);
      check("inorder_pc1", 64'(upd_pc), 64'h104);
      resolve(1'b1);
      check("inorder_pc2", 64'(upd_pc), 64'h108);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // flush with wrong-path allocation
      for (int i = 0; i < 4; i++) alloc(32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 12'h0F0);
      step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("flush_mispredict", {63'd0, upd_mispredict}, 64'd1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // choice training
      alloc(32'h400, 1'b1, 1'b1, 1'b0, 12'h000);
      resolve(1'b1);
      check("choice_dec", {62'd0, upd_choice_inc, upd_choice_dec}, 64'b01);
      alloc(32'h404, 1'b1, 1'b0, 1'b1, 12'h000);
      resolve(1'b1);
      check("choice_inc", {62'd0, upd_choice_inc, upd_choice_dec}, 64'b10);
      alloc(32'h408, 1'b1, 1'b1, 1'b1, 12'h000);
      resolve(1'b1);
      check("choice_none", {62'd0, upd_choice_inc, upd_choice_dec}, 64'b00);

      // GHR repair
      alloc(32'h500, 1'b1, 1'b1, 1'b1, 12'hABC);
      resolve(1'b1);
      check("ghr_repair", 64'(upd_ghr), 64'h579);

      // resolve on empty with same-cycle allocation
      step(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check("empty_res_count", 64'(count), 64'd1);
      drain();

      // randomized traffic with occasional mid-run reset
      pv_pct = 60;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) pv_pct = (c / 200) % 3 == 0 ? 30 : ((c / 200) % 3 == 1 ? 70 : 95);
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            if (model_q.size() > 0 && $urandom_range(0, 9) < 8) rt = model_q[0].taken;
            else rt = 1'($urandom_range(0, 1));
            step(1'b0, $urandom_range(0, 99) < pv_pct, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
                 $urandom_range(0, 99) < 45, rt);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
